// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter for a shared memory port (separate write/read channels,
// 1-cycle read latency), with an optional bounded lock for back-to-back accesses.
module mem_rr_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_w_en,
    output logic [AW-1:0] mem_w_addr,
    output logic [DW-1:0] mem_w_data,
    output logic          mem_r_en,
    output logic [AW-1:0] mem_r_addr,
    input  logic [DW-1:0] mem_r_data
);

    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } fsm_e;

    fsm_e          fsm_q;
    logic          last_gnt_q;
    logic [CW-1:0] lock_cnt_q;
    logic [CW-1:0] lock_cnt_d;
    logic          rd_pend_q;
    logic          rd_owner_q;

    logic any_gnt;
    logic sel;
    logic sel_we;
    logic sel_lock;

    // Grant decision: a locked owner keeps the port, otherwise alternate on contention.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (fsm_q)
                LOCK0: gnt0 = req0;
                LOCK1: gnt1 = req1;
                default: begin
                    if (req0 && req1) begin
                        gnt0 = last_gnt_q;
                        gnt1 = ~last_gnt_q;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
            endcase
        end
    end

    assign any_gnt    = gnt0 | gnt1;
    assign sel        = gnt1;
    assign sel_we     = sel ? we1   : we0;
    assign sel_lock   = sel ? lock1 : lock0;
    assign lock_cnt_d = lock_cnt_q + CW'(1);

    // With no grant, address/data fall back to requester 0 so nothing floats.
    assign mem_w_en   = any_gnt & sel_we;
    assign mem_w_addr = sel ? addr1  : addr0;
    assign mem_w_data = sel ? wdata1 : wdata0;
    assign mem_r_en   = any_gnt & ~sel_we;
    assign mem_r_addr = sel ? addr1  : addr0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= ARB;
            last_gnt_q <= 1'b1;
            lock_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            // Read return: data arrives one cycle after the read grant.
            rvalid0 <= rd_pend_q & ~rd_owner_q;
            rvalid1 <= rd_pend_q &  rd_owner_q;
            if (rd_pend_q && !rd_owner_q) rdata0 <= mem_r_data;
            if (rd_pend_q &&  rd_owner_q) rdata1 <= mem_r_data;
            rd_pend_q  <= any_gnt & ~sel_we;
            rd_owner_q <= sel;

            if (any_gnt) last_gnt_q <= sel;

            case (fsm_q)
                ARB: begin
                    if (any_gnt && sel_lock && (MAX_LOCK > 1)) begin
                        fsm_q      <= sel ? LOCK1 : LOCK0;
                        lock_cnt_q <= CW'(1);
                    end
                end
                LOCK0, LOCK1: begin
                    if (!any_gnt || !sel_lock || (lock_cnt_d == CW'(MAX_LOCK))) begin
                        fsm_q      <= ARB;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_d;
                    end
                end
                default: fsm_q <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios followed by random traffic, checked
// cycle by cycle against a behavioural arbiter/memory model.
module tb_mem_rr_arbiter;

    localparam int MAXL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       mem_w_en, mem_r_en;
    logic [7:0] mem_w_addr, mem_w_data, mem_r_addr;
    logic [7:0] mem_r_data = 8'h00;

    logic [7:0] mem     [256] = '{default: 8'h00};
    logic [7:0] exp_mem [256] = '{default: 8'h00};

    int tests = 0;
    int fails = 0;

    // stimulus held per requester
    logic       rq [2];
    logic       wq [2];
    logic [7:0] aq [2];
    logic [7:0] dq [2];
    logic       lq [2];

    // reference model state
    int         m_last, m_lockby, m_run, m_owner;
    bit         m_pend;
    logic [7:0] m_pdata;
    bit         m_rv [2];
    logic [7:0] m_rd [2];

    // observed values of the most recent cycle
    int         last_g;
    logic       obs_g0, obs_g1;
    logic [7:0] obs_wa;

    always #5 clk = ~clk;

    // memory responder: registered read, one-cycle latency
    always @(posedge clk) begin
        if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= mem[mem_r_addr];
    end

    mem_rr_arbiter #(.AW(8), .DW(8), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setr(input int n, input logic r, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic l);
        rq[n] = r; wq[n] = w; aq[n] = a; dq[n] = d; lq[n] = l;
    endtask

    // One clock cycle: drive, check grant/memory drive, clock, check read return.
    task automatic cyc(input logic rs);
        int         eg;
        bit         ewe, erd;
        logic [7:0] pdata;
        @(negedge clk);
        rst = rs;
        req0 = rq[0]; we0 = wq[0]; addr0 = aq[0]; wdata0 = dq[0]; lock0 = lq[0];
        req1 = rq[1]; we1 = wq[1]; addr1 = aq[1]; wdata1 = dq[1]; lock1 = lq[1];
        #1;
        eg = -1;
        if (!rs) begin
            if (m_lockby >= 0) begin
                if (rq[m_lockby]) eg = m_lockby;
            end else if (rq[0] && rq[1]) eg = 1 - m_last;
            else if (rq[0]) eg = 0;
            else if (rq[1]) eg = 1;
        end
        ewe = (eg >= 0) && wq[eg];
        erd = (eg >= 0) && !wq[eg];
        chk("gnt0", gnt0, eg == 0);
        chk("gnt1", gnt1, eg == 1);
        chk("mem_w_en", mem_w_en, ewe);
        chk("mem_r_en", mem_r_en, erd);
        if (ewe) begin
            chk("mem_w_addr", mem_w_addr, aq[eg]);
            chk("mem_w_data", mem_w_data, dq[eg]);
        end
        if (erd) chk("mem_r_addr", mem_r_addr, aq[eg]);
        pdata  = erd ? exp_mem[aq[eg]] : 8'h00;
        obs_g0 = gnt0; obs_g1 = gnt1; obs_wa = mem_w_addr;
        last_g = eg;
        @(posedge clk);
        #1;
        if (rs) begin
            m_last = 1; m_lockby = -1; m_run = 0; m_pend = 0;
            m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
        end else begin
            m_rv[0] = m_pend && (m_owner == 0);
            m_rv[1] = m_pend && (m_owner == 1);
            if (m_pend) m_rd[m_owner] = m_pdata;
            m_pend = erd; m_owner = eg; m_pdata = pdata;
            if (ewe) exp_mem[aq[eg]] = dq[eg];
            if (eg >= 0) m_last = eg;
            // lock bookkeeping: count consecutive locked grants, capped at MAXL
            if (m_lockby < 0) begin
                if (eg >= 0 && lq[eg] && MAXL > 1) begin m_lockby = eg; m_run = 1; end
            end else if (eg < 0 || !lq[eg]) begin
                m_lockby = -1;
            end else begin
                m_run++;
                if (m_run == MAXL) m_lockby = -1;
            end
        end
        chk("rvalid0", rvalid0, m_rv[0]);
        chk("rvalid1", rvalid1, m_rv[1]);
        chk("rdata0", rdata0, m_rd[0]);
        chk("rdata1", rdata1, m_rd[1]);
    endtask

    initial begin
        bit eg0 [6];
        m_last = 1; m_lockby = -1; m_run = 0; m_owner = 0; m_pend = 0; m_pdata = 8'h00;
        m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = 8'h00; m_rd[1] = 8'h00; last_g = -1;
        setr(0, 0, 0, 8'h00, 8'h00, 0);
        setr(1, 0, 0, 8'h00, 8'h00, 0);
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;

        // reset, then a store and a single read
        cyc(1); cyc(1);
        setr(0, 1, 1, 8'h10, 8'h5A, 0); cyc(0);
        setr(0, 1, 0, 8'h10, 8'h00, 0); cyc(0);
        chk("rd_gnt0", obs_g0, 1'b1);
        setr(0, 0, 0, 8'h00, 8'h00, 0); cyc(0);
        chk("rd_rvalid0", rvalid0, 1'b1);
        chk("rd_rdata0", rdata0, 8'h5A);
        chk("rd_rvalid1", rvalid1, 1'b0);

        // contention: both writing, grants strictly alternate 0,1,0,1
        setr(1, 1, 1, 8'h40, 8'h33, 0); cyc(0);
        setr(0, 1, 1, 8'h20, 8'h11, 0);
        setr(1, 1, 1, 8'h30, 8'h22, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0);
            chk("alt_gnt0", obs_g0, (i % 2) == 0);
            chk("alt_waddr", obs_wa, ((i % 2) == 0) ? 8'h20 : 8'h30);
        end

        // lock capped at MAXL grants, then the other requester gets the port
        eg0 = '{1, 1, 1, 1, 0, 1};
        setr(0, 1, 1, 8'h21, 8'h44, 1);
        setr(1, 1, 1, 8'h31, 8'h55, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0);
            chk("lock_gnt0", obs_g0, eg0[i]);
            chk("lock_gnt1", obs_g1, !eg0[i]);
        end
        setr(0, 0, 0, 8'h00, 8'h00, 0);
        setr(1, 0, 0, 8'h00, 8'h00, 0); cyc(0);
        setr(1, 1, 1, 8'h41, 8'h66, 0); cyc(0);

        // early unlock on the third locked cycle
        setr(0, 1, 1, 8'h22, 8'h77, 1);
        setr(1, 1, 1, 8'h32, 8'h88, 0);
        cyc(0); chk("unl_gnt0_c1", obs_g0, 1'b1);
        cyc(0); chk("unl_gnt0_c2", obs_g0, 1'b1);
        setr(0, 1, 1, 8'h22, 8'h77, 0);
        cyc(0); chk("unl_gnt0_c3", obs_g0, 1'b1);
        setr(0, 0, 0, 8'h00, 8'h00, 0);
        cyc(0); chk("unl_gnt1_c4", obs_g1, 1'b1);
        setr(1, 0, 0, 8'h00, 8'h00, 0);

        // back-to-back reads with alternating owners
        setr(0, 1, 1, 8'h01, 8'hA1, 0); cyc(0);
        setr(0, 0, 0, 8'h00, 8'h00, 0);
        setr(1, 1, 1, 8'h02, 8'hB2, 0); cyc(0);
        setr(1, 0, 0, 8'h00, 8'h00, 0);
        setr(0, 1, 0, 8'h01, 8'h00, 0); cyc(0);
        setr(0, 0, 0, 8'h00, 8'h00, 0);
        setr(1, 1, 0, 8'h02, 8'h00, 0); cyc(0);
        chk("b2b_rvalid0", rvalid0, 1'b1);
        chk("b2b_rdata0", rdata0, 8'hA1);
        setr(1, 0, 0, 8'h00, 8'h00, 0); cyc(0);
        chk("b2b_rvalid1", rvalid1, 1'b1);
        chk("b2b_rdata1", rdata1, 8'hB2);
        chk("b2b_rvalid0_off", rvalid0, 1'b0);

        // reset right after a read grant drops the response
        setr(0, 1, 0, 8'h10, 8'h00, 0); cyc(0);
        setr(0, 0, 0, 8'h00, 8'h00, 0); cyc(1);
        chk("rstrd_rvalid0", rvalid0, 1'b0);
        chk("rstrd_rdata0", rdata0, 8'h00);
        chk("rstrd_rdata1", rdata1, 8'h00);
        setr(0, 1, 1, 8'h05, 8'h01, 0);
        setr(1, 1, 1, 8'h06, 8'h02, 0);
        cyc(0); chk("rstrd_gnt0_first", obs_g0, 1'b1);
        cyc(0);
        setr(0, 0, 0, 8'h00, 8'h00, 0);
        setr(1, 0, 0, 8'h00, 8'h00, 0);

        // random traffic; fields held until granted
        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!rq[n] || last_g == n) begin
                    setr(n, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                         8'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 9) < 3);
                end
            end
            cyc($urandom_range(0, 99) < 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
